// File: rtl/char_pkg.sv
// Shared constants for the character stream arbiter: widths, the newline code
// and the FSM state encodings used by char_stream_arbiter and char_serializer.
package char_pkg;
    localparam int CHAR_W = 8;
    localparam int LEN_W  = 4;

    localparam logic [CHAR_W-1:0] CHAR_NL = 8'h0A;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] NL   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/char_serializer.sv
// Shadow copy of the granted line buffer plus the character index; steps one
// byte per valid/ready handshake and flags the last byte of the latched length.
module char_serializer
    import char_pkg::*;
#(
    parameter int NUM_CHARS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [8*NUM_CHARS-1:0]  load_buf,
    input  logic [LEN_W-1:0]        load_len,
    input  logic                    valid,
    input  logic                    ready,
    output logic [CHAR_W-1:0]       char_data,
    output logic                    last
);

    logic [NUM_CHARS-1:0][CHAR_W-1:0] shadow;
    logic [LEN_W-1:0]                 len;
    logic [LEN_W-1:0]                 idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            len    <= '0;
            idx    <= '0;
        end else if (load) begin
            shadow <= load_buf;
            len    <= load_len;
            idx    <= '0;
        end else if (valid && ready) begin
            // len never exceeds 15, so idx cannot wrap past the last byte
            idx <= idx + 1'b1;
        end
    end

    assign char_data = shadow[idx];
    assign last      = (idx == len - 1'b1);

endmodule

// File: rtl/char_stream_arbiter.sv
// Round-robin arbiter that serialises one of two line buffers onto a single
// character stream. Define CHAR_ARB_NEWLINE_EN to append 8'h0A to every transfer.
module char_stream_arbiter
    import char_pkg::*;
#(
    parameter int NUM_CHARS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic [8*NUM_CHARS-1:0]  buf0,
    input  logic [LEN_W-1:0]        len0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic [8*NUM_CHARS-1:0]  buf1,
    input  logic [LEN_W-1:0]        len1,
    output logic                    ack1,
    output logic [1:0]              grant,
    output logic [CHAR_W-1:0]       char_out,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic                    busy
);

`ifdef CHAR_ARB_NEWLINE_EN
    localparam logic [1:0] AFTER_SEND = NL;
`else
    localparam logic [1:0] AFTER_SEND = DONE;
`endif

    logic [1:0]              state;
    logic [1:0]              grant_q;
    // Requester favoured on a tie; it is always the one that did not win last.
    logic                    prio;
    logic                    win1;
    logic                    any_req;
    logic                    load;
    logic [8*NUM_CHARS-1:0]  sel_buf;
    logic [LEN_W-1:0]        sel_len;
    logic [CHAR_W-1:0]       ser_char;
    logic                    ser_last;

    assign any_req = req0 | req1;
    assign win1    = req1 & (~req0 | prio);
    assign sel_buf = win1 ? buf1 : buf0;
    assign sel_len = win1 ? len1 : len0;
    assign load    = (state == IDLE) && any_req;

    char_serializer #(
        .NUM_CHARS (NUM_CHARS)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_buf  (sel_buf),
        .load_len  (sel_len),
        .valid     (state == SEND),
        .ready     (char_ready),
        .char_data (ser_char),
        .last      (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            prio    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win1 ? 2'b10 : 2'b01;
                        state   <= (sel_len == '0) ? AFTER_SEND : SEND;
                    end
                end
                SEND: begin
                    if (char_ready && ser_last) state <= AFTER_SEND;
                end
`ifdef CHAR_ARB_NEWLINE_EN
                NL: begin
                    if (char_ready) state <= DONE;
                end
`endif
                DONE: begin
                    prio    <= grant_q[0];
                    grant_q <= 2'b00;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        char_valid = 1'b0;
        char_out   = '0;
        case (state)
            SEND: begin
                char_valid = 1'b1;
                char_out   = ser_char;
            end
`ifdef CHAR_ARB_NEWLINE_EN
            NL: begin
                char_valid = 1'b1;
                char_out   = CHAR_NL;
            end
`endif
            default: ;
        endcase
    end

    assign ack0  = (state == DONE) && grant_q[0];
    assign ack1  = (state == DONE) && grant_q[1];
    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_char_stream_arbiter.sv
// Scoreboard bench for char_stream_arbiter; follows CHAR_ARB_NEWLINE_EN when the
// macro is defined for the build.
module tb_char_stream_arbiter;
    import char_pkg::*;

`ifdef CHAR_ARB_NEWLINE_EN
    localparam int NLN = 1;
`else
    localparam int NLN = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [127:0] buf0 = '0, buf1 = '0;
    logic [3:0]   len0 = '0, len1 = '0;
    logic         ack0, ack1;
    logic [1:0]   grant;
    logic [7:0]   char_out;
    logic         char_valid;
    logic         char_ready = 1'b0;
    logic         busy;

    logic [7:0] exp_q[$];
    // {id, 2'b0, expected accepted-character count} per transfer
    logic [7:0] exp_ack_q[$];
    int vectors = 0;
    int errors = 0;
    logic tb_fav = 1'b0;

    char_stream_arbiter #(.NUM_CHARS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .buf0       (buf0),
        .len0       (len0),
        .ack0       (ack0),
        .req1       (req1),
        .buf1       (buf1),
        .len1       (len1),
        .ack1       (ack1),
        .grant      (grant),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [127:0] b, input logic [3:0] l);
        logic [4:0] cnt;
        for (int i = 0; i < int'(l); i++) exp_q.push_back(b[8*i +: 8]);
        if (NLN == 1) exp_q.push_back(8'h0A);
        cnt = 5'(l) + 5'(NLN);
        exp_ack_q.push_back({id[0], 2'b00, cnt});
    endtask

    task automatic drive_req(input int id, input logic [127:0] b, input logic [3:0] l);
        if (id == 0) begin
            req0 = 1'b1; buf0 = b; len0 = l;
        end else begin
            req1 = 1'b1; buf1 = b; len1 = l;
        end
    endtask

    task automatic single_request(input int id, input logic [127:0] b, input logic [3:0] l);
        push_exp(id, b, l);
        drive_req(id, b, l);
        tb_fav = ~id[0];
    endtask

    task automatic both_request(input logic [127:0] b0, input logic [3:0] l0,
                                input logic [127:0] b1, input logic [3:0] l1);
        if (tb_fav == 1'b0) begin
            push_exp(0, b0, l0); push_exp(1, b1, l1);
        end else begin
            push_exp(1, b1, l1); push_exp(0, b0, l0);
        end
        drive_req(0, b0, l0);
        drive_req(1, b1, l1);
    endtask

    task automatic run_until_idle(input int rand_ready);
        int n = 0;
        while ((req0 || req1 || busy) && n < 300) begin
            char_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        check("run_timeout", (n < 300), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; char_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        tb_fav = 1'b0;
    endtask

    function automatic logic [127:0] rand_buf();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic monitor();
        logic       stall_prev = 1'b0;
        logic [7:0] prev_char = '0;
        logic [7:0] e;
        int         acc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_ack_q.delete();
                acc = 0;
                stall_prev = 1'b0;
            end else begin
                check("busy_vs_grant", busy, (grant != 2'b00));
                if (!char_valid) check("idle_char", char_out, 0);
                if (stall_prev) begin
                    check("hold_valid", char_valid, 1);
                    check("hold_char", char_out, prev_char);
                end
                stall_prev = char_valid && !char_ready;
                prev_char = char_out;
                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) check("char_unexpected", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        check("char", char_out, e);
                    end
                    acc++;
                end
                if (ack0 || ack1) begin
                    if (exp_ack_q.size() == 0) check("ack_unexpected", exp_ack_q.size(), 1);
                    else begin
                        e = exp_ack_q.pop_front();
                        check("ack_id", {ack1, ack0}, e[7] ? 2'b10 : 2'b01);
                        check("ack_grant", grant, e[7] ? 2'b10 : 2'b01);
                        check("ack_count", acc, e[4:0]);
                    end
                    acc = 0;
                end
            end
        end
    endtask

    initial begin
        logic [127:0] hello;
        logic [127:0] b;
        logic         pat [8];
        int           n;
        hello = 128'h4F4C4C4548;
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        fork
            monitor();
        join_none

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_valid", char_valid, 0);
        check("rst_char", char_out, 0);
        check("rst_acks", {ack1, ack0}, 0);

        // HELLO on requester 0, one-cycle latency to grant and first character
        single_request(0, hello, 4'd5);
        char_ready = 1'b1;
        step();
        check("lat_grant", grant, 2'b01);
        check("lat_valid", char_valid, 1);
        check("first_char", char_out, 8'h48);
        run_until_idle(0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);

        // Simultaneous requests after reset, twice: grant alternates 01,10,01,10
        do_reset();
        both_request(rand_buf(), 4'd3, rand_buf(), 4'd2);
        run_until_idle(0);
        both_request(rand_buf(), 4'd2, rand_buf(), 4'd4);
        run_until_idle(0);
        // A lone req0 win moves the tie-break to requester 1
        single_request(0, rand_buf(), 4'd1);
        run_until_idle(0);
        both_request(rand_buf(), 4'd2, rand_buf(), 4'd3);
        run_until_idle(0);

        // Backpressure during SEND with len=3
        single_request(0, rand_buf(), 4'd3);
        for (int i = 0; i < 8; i++) begin
            char_ready = pat[i];
            step();
            if (ack0) req0 = 1'b0;
        end
        run_until_idle(0);

        // Zero-length transfer from requester 1
        single_request(1, rand_buf(), 4'd0);
        char_ready = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack1 && n < 10);
        check("len0_ack_latency", n, 1 + NLN);
        req1 = 1'b0;
        run_until_idle(0);

        // Reset while at idx=2 drops the transfer with no ack
        b = rand_buf();
        single_request(0, b, 4'd5);
        char_ready = 1'b1;
        step(); step(); step();
        rst_n = 1'b0; char_ready = 1'b0; req0 = 1'b0;
        step();
        check("midrst_busy", busy, 0);
        check("midrst_grant", grant, 0);
        check("midrst_valid", char_valid, 0);
        check("midrst_ack", {ack1, ack0}, 0);
        rst_n = 1'b1;
        tb_fav = 1'b0;
        single_request(0, b, 4'd5);
        run_until_idle(0);

        // Producer inputs changing after grant must not affect the stream
        single_request(0, rand_buf(), 4'd6);
        char_ready = 1'b1;
        step();
        buf0 = rand_buf();
        len0 = 4'($urandom_range(0, 15));
        run_until_idle(1);

        // Random traffic with random backpressure
        for (int t = 0; t < 10; t++) begin
            if (t % 3 == 2)
                both_request(rand_buf(), 4'($urandom_range(0, 15)),
                             rand_buf(), 4'($urandom_range(0, 15)));
            else
                single_request(t % 2, rand_buf(), 4'($urandom_range(0, 15)));
            run_until_idle(1);
        end

        step();
        check("drain_chars", exp_q.size(), 0);
        check("drain_acks", exp_ack_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
